multiplicador_seq: RTL and testbench

- Sequential shift-and-add unsigned multiplier.
- Sits directly downstream of the operand-entry controller.
- Consumes its compute strobe and the A/B operands, produces a 2*WIDTH-bit product and a done flag for the display stage.
- One operand bit is processed per clock, so the block is small enough for the FPGA lab board.

---
 rtl/multiplicador_seq.sv | 147 ++++++++++++++
 tb/tb_multiplicador_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq.sv
// Purpose: sequential shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
// Latency: start captured at edge N, product_o/done_o valid after edge N+WIDTH.
// Backpressure: none; a new operation needs compute_i to fall and rise again after DONE.
module multiplicador_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 compute_i,
    input  logic [WIDTH-1:0]     A_i,
    input  logic [WIDTH-1:0]     B_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           fsm_state_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;

    // compute_i delay for rising-edge detection
    logic            compute_q;
    // Set once compute_i has been seen low since reset; a level that is
    // already high when reset is released must not count as a start.
    logic            armed_q;
    logic            start;

    // Datapath: shifted multiplicand, shifted multiplier, running sum
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    product_q;
    logic [CW-1:0]    cnt_q;
    logic             last_iter;

    assign start     = compute_i & ~compute_q & armed_q;
    assign last_iter = (cnt_q == LAST_CNT);

    // Add this iteration's partial product when the current multiplier bit is set
    always_comb begin
        acc_sum = acc_q;
        if (mplier_q[0]) begin
            acc_sum = acc_q + mcand_q;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!compute_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Edge-detect registers track compute_i in every state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            compute_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            compute_q <= compute_i;
            if (!compute_i) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Operand shadowing on start, one shift-and-add step per clock in RUN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, A_i};
                        mplier_q <= B_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_iter) begin
                        product_q <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs are plain decodes of the state register
    always_comb begin
        product_o   = product_q;
        busy_o      = (state_q == ST_RUN);
        done_o      = (state_q == ST_DONE);
        fsm_state_o = state_q;
    end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Directed bench for multiplicador_seq at WIDTH=4 and WIDTH=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected products are hand-computed constants.
module tb_multiplicador_seq;

    logic        clk;
    logic        rst;

    logic        c4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  p4;
    logic        busy4;
    logic        done4;
    logic [1:0]  st4;

    logic        c8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] p8;
    logic        busy8;
    logic        done8;
    logic [1:0]  st8;

    int errors = 0;
    int checks = 0;

    multiplicador_seq #(.WIDTH(4)) u4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .compute_i   (c4),
        .A_i         (a4),
        .B_i         (b4),
        .product_o   (p4),
        .busy_o      (busy4),
        .done_o      (done4),
        .fsm_state_o (st4)
    );

    multiplicador_seq #(.WIDTH(8)) u8 (
        .clk_i       (clk),
        .rst_i       (rst),
        .compute_i   (c8),
        .A_i         (a8),
        .B_i         (b8),
        .product_o   (p8),
        .busy_o      (busy8),
        .done_o      (done8),
        .fsm_state_o (st8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a WIDTH=4 operation and follow it until done_o (bounded).
    // scramble: change operands every RUN clock; drop: release compute_i after capture.
    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input logic [7:0] prev,
                        input bit scramble, input bit drop);
        int nbusy;
        int nhold;
        nbusy = 0;
        nhold = 0;
        a4 = a;
        b4 = b;
        c4 = 1'b1;
        tick();                         // capture edge
        if (drop) c4 = 1'b0;
        for (int i = 0; i < 12 && !done4; i++) begin
            if (busy4) nbusy++;
            if (p4 !== prev) nhold++;
            if (scramble) begin
                a4 = 4'($urandom_range(15));
                b4 = 4'($urandom_range(15));
            end
            tick();
        end
        chk({tag, "_busy_clocks"}, nbusy, 4);
        chk({tag, "_product_held_in_run"}, nhold, 0);
        chk({tag, "_done"}, done4, 1);
        chk({tag, "_state"}, st4, 2);
        chk({tag, "_product"}, p4, exp);
    endtask

    initial begin
        int bad;
        int nbusy;
        rst = 1'b0;
        c4  = 1'b0; a4 = '0; b4 = '0;
        c8  = 1'b0; a8 = '0; b8 = '0;
        #3;
        chk("rst_product4", p4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_state4", st4, 0);
        chk("rst_product8", p8, 0);
        chk("rst_state8", st8, 0);
        #20;
        rst = 1'b1;
        tick();
        tick();
        chk("idle_after_reset", st4, 0);

        // 3 x 5, then release compute_i
        run4("mul_3x5", 4'd3, 4'd5, 8'd15, 8'd0, 1'b0, 1'b0);
        c4 = 1'b0;
        tick();
        chk("3x5_back_idle", st4, 0);
        chk("3x5_done_low", done4, 0);
        chk("3x5_retained", p4, 15);

        // zero operand still takes the full WIDTH clocks
        run4("mul_0x9", 4'd0, 4'd9, 8'd0, 8'd15, 1'b0, 1'b0);
        c4 = 1'b0;
        tick();

        // 15 x 15 then hold compute_i high for 50 clocks
        run4("mul_15x15", 4'd15, 4'd15, 8'd225, 8'd0, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            a4 = 4'($urandom_range(15));
            tick();
            if (st4 !== 2'd2 || p4 !== 8'd225 || busy4 !== 1'b0 || done4 !== 1'b1) bad++;
        end
        chk("hold_done_50", bad, 0);
        c4 = 1'b0;
        tick();
        chk("hold_drop_state", st4, 0);
        chk("hold_drop_done", done4, 0);
        chk("hold_drop_product", p4, 225);

        run4("mul_7x6", 4'd7, 4'd6, 8'd42, 8'd225, 1'b0, 1'b0);
        c4 = 1'b0;
        tick();

        // operands scrambled during RUN are ignored
        run4("mul_9x11_scramble", 4'd9, 4'd11, 8'd99, 8'd42, 1'b1, 1'b0);
        c4 = 1'b0;
        tick();

        // compute_i dropped during RUN: completes, then IDLE on the next clock
        run4("mul_2x3_drop", 4'd2, 4'd3, 8'd6, 8'd99, 1'b0, 1'b1);
        tick();
        chk("drop_back_idle", st4, 0);
        chk("drop_product", p4, 6);

        // asynchronous reset on the 2nd RUN clock
        a4 = 4'd9; b4 = 4'd11; c4 = 1'b1;
        tick();                          // capture
        tick();                          // 1st RUN iteration done, in 2nd RUN clock
        chk("pre_abort_busy", busy4, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_product", p4, 0);
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        chk("abort_state", st4, 0);
        #3;
        rst = 1'b1;                      // compute_i still high across release
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (st4 !== 2'd0 || busy4 !== 1'b0) bad++;
        end
        chk("no_start_on_held_level", bad, 0);
        c4 = 1'b0;
        tick();
        run4("mul_5x4_after_reset", 4'd5, 4'd4, 8'd20, 8'd0, 1'b0, 1'b0);
        c4 = 1'b0;
        tick();

        // WIDTH=8: 200 x 250
        a8 = 8'd200; b8 = 8'd250; c8 = 1'b1;
        tick();                          // capture
        nbusy = 0;
        for (int i = 0; i < 20 && !done8; i++) begin
            if (busy8) nbusy++;
            tick();
        end
        chk("w8_busy_clocks", nbusy, 8);
        chk("w8_done", done8, 1);
        chk("w8_state", st8, 2);
        chk("w8_product", p8, 50000);
        c8 = 1'b0;
        tick();
        chk("w8_back_idle", st8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
